// File: rtl/bus_uart.sv
// bus_uart: memory-mapped UART slave with byte FIFOs, programmable bit period and level IRQ.
// Optional build macro UART_LOOPBACK_EN implements CTRL[2] (internal TX->RX loopback).
//
// state | meaning
// IDLE  | line idle; TX waits for FIFO data, RX waits for a falling edge
// START | start bit; TX drives 0, RX re-checks the line mid-bit
// DATA  | 8 data bits, LSB first
// STOP  | stop bit; TX drives 1, RX validates and pushes the byte
module bus_uart #(
    parameter int          FIFO_DEPTH = 8,
    parameter logic [15:0] DIV_RESET  = 16'd434
) (
    input  logic        clk,
    input  logic        rst_n_i,
    input  logic        stb_i,
    input  logic        we_i,
    input  logic [3:0]  adr_i,
    input  logic [31:0] dat_i,
    input  logic [3:0]  sel_i,
    output logic [31:0] dat_o,
    output logic        ack_o,
    output logic        irq_o,
    input  logic        rxd_i,
    output logic        txd_o
);
    localparam int          AW      = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;

    logic [2:0]  ctrl;
    logic [15:0] divisor;
    logic        rx_overrun, frame_err;
    logic        loopback, lb_wr;
    logic        acc, wr_en, rd_en;
    logic [1:0]  reg_sel;
    logic [31:0] rdata, status;
    logic        unused_bits;

    logic [7:0]  tx_mem [FIFO_DEPTH];
    logic [AW:0] tx_wp, tx_rp;
    logic        tx_fifo_empty, tx_full, tx_push_ok, tx_pop_ok, tx_done;
    logic [7:0]  rx_mem [FIFO_DEPTH];
    logic [AW:0] rx_wp, rx_rp;
    logic        rx_empty, rx_full, rx_push_ok, rx_pop_ok, rx_valid, rx_pop_req;

    uart_state_t tx_state, tx_next;
    logic [15:0] tx_cnt;
    logic [2:0]  tx_bit;
    logic [7:0]  tx_shift;
    logic        tx_load, tx_pop, tx_ser, tx_tc;

    uart_state_t rx_state, rx_next;
    logic [15:0] rx_cnt;
    logic [2:0]  rx_bit;
    logic [7:0]  rx_shift;
    logic        rx_s1, rx_s2, rx_s3, rx_in, rx_tc;
    logic        rx_load_half, rx_load_full, rx_sample, rx_push_req, frame_set;

`ifdef UART_LOOPBACK_EN
    assign loopback = ctrl[2];
    assign lb_wr    = dat_i[2];
`else
    assign loopback = 1'b0;
    assign lb_wr    = 1'b0;
`endif

    assign unused_bits = &{1'b0, dat_i[31:16], dat_i[3:2], adr_i[1:0], sel_i[3:1]};

    // A transfer takes effect only on the edge where ack rises.
    assign acc     = stb_i && !ack_o;
    assign reg_sel = adr_i[3:2];
    assign wr_en   = acc && we_i && sel_i[0];
    assign rd_en   = acc && !we_i;

    assign tx_fifo_empty = (tx_wp == tx_rp);
    assign tx_full    = (tx_wp[AW] != tx_rp[AW]) && (tx_wp[AW-1:0] == tx_rp[AW-1:0]);
    assign tx_pop_ok  = tx_pop && !tx_fifo_empty;
    assign tx_push_ok = wr_en && (reg_sel == 2'd0) && (!tx_full || tx_pop_ok);
    assign tx_done    = tx_fifo_empty && (tx_state == IDLE);

    assign rx_empty   = (rx_wp == rx_rp);
    assign rx_full    = (rx_wp[AW] != rx_rp[AW]) && (rx_wp[AW-1:0] == rx_rp[AW-1:0]);
    assign rx_valid   = !rx_empty;
    assign rx_pop_req = rd_en && (reg_sel == 2'd0);
    assign rx_pop_ok  = rx_pop_req && !rx_empty;
    assign rx_push_ok = rx_push_req && (!rx_full || rx_pop_ok);

    assign status = {26'h0, frame_err, rx_overrun, tx_done, tx_full, rx_full, rx_valid};

    always_comb begin
        rdata = 32'h0;
        case (reg_sel)
            2'd0: rdata = {24'h0, rx_empty ? 8'h00 : rx_mem[rx_rp[AW-1:0]]};
            2'd1: rdata = status;
            2'd2: rdata = {29'h0, ctrl};
            2'd3: rdata = {16'h0, divisor};
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ack_o      <= 1'b0;
            dat_o      <= 32'h0;
            irq_o      <= 1'b0;
            ctrl       <= 3'h0;
            divisor    <= DIV_RESET;
            rx_overrun <= 1'b0;
            frame_err  <= 1'b0;
            tx_wp      <= '0;
            tx_rp      <= '0;
            rx_wp      <= '0;
            rx_rp      <= '0;
        end else begin
            ack_o <= stb_i;
            if (acc) dat_o <= we_i ? 32'h0 : rdata;
            irq_o <= (ctrl[0] && rx_valid) || (ctrl[1] && tx_done);
            if (wr_en && reg_sel == 2'd2) ctrl <= {lb_wr, dat_i[1:0]};
            if (wr_en && reg_sel == 2'd3) divisor <= (dat_i[15:0] < 16'd2) ? 16'd2 : dat_i[15:0];
            if (rx_push_req && !rx_push_ok) rx_overrun <= 1'b1;
            else if (wr_en && reg_sel == 2'd1 && dat_i[4]) rx_overrun <= 1'b0;
            if (frame_set) frame_err <= 1'b1;
            else if (wr_en && reg_sel == 2'd1 && dat_i[5]) frame_err <= 1'b0;
            if (tx_push_ok) tx_wp <= tx_wp + PTR_ONE;
            if (tx_pop_ok)  tx_rp <= tx_rp + PTR_ONE;
            if (rx_push_ok) rx_wp <= rx_wp + PTR_ONE;
            if (rx_pop_ok)  rx_rp <= rx_rp + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (tx_push_ok) tx_mem[tx_wp[AW-1:0]] <= dat_i[7:0];
        if (rx_push_ok) rx_mem[rx_wp[AW-1:0]] <= rx_shift;
    end

    // Transmitter
    assign tx_tc = (tx_cnt == 16'd0);

    always_comb begin
        tx_next = tx_state;
        tx_load = 1'b0;
        tx_pop  = 1'b0;
        tx_ser  = 1'b1;
        case (tx_state)
            IDLE: if (!tx_fifo_empty) begin
                tx_pop  = 1'b1;
                tx_load = 1'b1;
                tx_next = START;
            end
            START: begin
                tx_ser = 1'b0;
                if (tx_tc) begin
                    tx_load = 1'b1;
                    tx_next = DATA;
                end
            end
            DATA: begin
                tx_ser = tx_shift[0];
                if (tx_tc) begin
                    tx_load = 1'b1;
                    if (tx_bit == 3'd7) tx_next = STOP;
                end
            end
            STOP: if (tx_tc) begin
                if (!tx_fifo_empty) begin
                    tx_pop  = 1'b1;
                    tx_load = 1'b1;
                    tx_next = START;
                end else begin
                    tx_next = IDLE;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n_i) begin
        if (!rst_n_i) begin
            tx_state <= IDLE;
            tx_cnt   <= 16'd0;
            tx_bit   <= 3'd0;
            tx_shift <= 8'h00;
        end else begin
            tx_state <= tx_next;
            if (tx_load) tx_cnt <= divisor - 16'd1;
            else if (!tx_tc) tx_cnt <= tx_cnt - 16'd1;
            if (tx_pop) begin
                tx_shift <= tx_mem[tx_rp[AW-1:0]];
                tx_bit   <= 3'd0;
            end else if (tx_state == DATA && tx_tc) begin
                tx_shift <= {1'b0, tx_shift[7:1]};
                tx_bit   <= tx_bit + 3'd1;
            end
        end
    end

    assign txd_o = loopback ? 1'b1 : tx_ser;

    // Receiver
    assign rx_in = loopback ? tx_ser : rxd_i;
    assign rx_tc = (rx_cnt == 16'd0);

    always_comb begin
        rx_next      = rx_state;
        rx_load_half = 1'b0;
        rx_load_full = 1'b0;
        rx_sample    = 1'b0;
        rx_push_req  = 1'b0;
        frame_set    = 1'b0;
        case (rx_state)
            IDLE: if (rx_s3 && !rx_s2) begin
                rx_load_half = 1'b1;
                rx_next      = START;
            end
            START: if (rx_tc) begin
                if (rx_s2) begin
                    rx_next = IDLE;
                end else begin
                    rx_load_full = 1'b1;
                    rx_next      = DATA;
                end
            end
            DATA: if (rx_tc) begin
                rx_sample    = 1'b1;
                rx_load_full = 1'b1;
                if (rx_bit == 3'd7) rx_next = STOP;
            end
            STOP: if (rx_tc) begin
                rx_next     = IDLE;
                rx_push_req = rx_s2;
                frame_set   = !rx_s2;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rx_s1    <= 1'b1;
            rx_s2    <= 1'b1;
            rx_s3    <= 1'b1;
            rx_state <= IDLE;
            rx_cnt   <= 16'd0;
            rx_bit   <= 3'd0;
            rx_shift <= 8'h00;
        end else begin
            rx_s1    <= rx_in;
            rx_s2    <= rx_s1;
            rx_s3    <= rx_s2;
            rx_state <= rx_next;
            if (rx_load_half) rx_cnt <= (divisor >> 1) - 16'd1;
            else if (rx_load_full) rx_cnt <= divisor - 16'd1;
            else if (!rx_tc) rx_cnt <= rx_cnt - 16'd1;
            if (rx_state == START) rx_bit <= 3'd0;
            else if (rx_sample) rx_bit <= rx_bit + 3'd1;
            if (rx_sample) rx_shift <= {rx_s2, rx_shift[7:1]};
        end
    end
endmodule
